// File: rtl/head_collect.sv
// head_collect: gathers head-major token beats into one packed
// [token][head][dim] frame and hands it downstream with a valid/ready pair.

// One storage slot = one (token, head) vector of HEAD_DIM elements.
module head_collect_slot #(
  parameter int W = 16
) (
  input  logic         clk_p,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  // Slot register: cleared by reset, otherwise only overwritten by its own beat.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= din;
  end

endmodule

module head_collect #(
  parameter int DATA_WIDTH = 8,
  parameter int SEQ_LEN    = 128,
  parameter int HEAD_NUM   = 12,
  parameter int HEAD_DIM   = 64
) (
  input  logic                                              clk_p,
  input  logic                                              rst_n,
  input  logic                                              clear,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [DATA_WIDTH*HEAD_DIM-1:0]                    in_data,
  input  logic                                              in_last,
  output logic [DATA_WIDTH*SEQ_LEN*HEAD_NUM*HEAD_DIM-1:0]   matrix,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic                                              err
);

  localparam int VW = DATA_WIDTH * HEAD_DIM;
  localparam int TW = (SEQ_LEN  > 1) ? $clog2(SEQ_LEN)  : 1;
  localparam int HW = (HEAD_NUM > 1) ? $clog2(HEAD_NUM) : 1;
  localparam logic [TW-1:0] TOK_LAST  = TW'(SEQ_LEN - 1);
  localparam logic [HW-1:0] HEAD_LAST = HW'(HEAD_NUM - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tok_cnt, tok_nxt;
  logic [HW-1:0]   head_cnt, head_nxt;
  logic            err_nxt;
  logic            accept;
  logic            tok_last;
  logic            head_last;

  // Ready and valid come straight from the state register.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == FULL);

  // A beat presented alongside clear is dropped.
  assign accept    = in_valid & in_ready & ~clear;
  assign tok_last  = (tok_cnt == TOK_LAST);
  assign head_last = (head_cnt == HEAD_LAST);

  // State, counters and sticky error register.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      tok_cnt  <= '0;
      head_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tok_cnt  <= tok_nxt;
      head_cnt <= head_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state: clear wins; FILL walks tokens then heads; FULL waits for out_ready.
  always_comb begin
    state_nxt = state;
    tok_nxt   = tok_cnt;
    head_nxt  = head_cnt;
    err_nxt   = err;
    if (clear) begin
      state_nxt = FILL;
      tok_nxt   = '0;
      head_nxt  = '0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            // in_last must agree with the token counter; a mismatch only flags.
            if (in_last != tok_last) err_nxt = 1'b1;
            if (tok_last) begin
              tok_nxt = '0;
              if (head_last) begin
                head_nxt  = '0;
                state_nxt = FULL;
              end else begin
                head_nxt = head_cnt + 1'b1;
              end
            end else begin
              tok_nxt = tok_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) state_nxt = FILL;
        end
      endcase
    end
  end

  // One slot per (token, head); slot index t*HEAD_NUM+h gives the output layout.
  for (genvar t = 0; t < SEQ_LEN; t++) begin : g_tok
    for (genvar h = 0; h < HEAD_NUM; h++) begin : g_head
      localparam logic [TW-1:0] T_IDX = TW'(t);
      localparam logic [HW-1:0] H_IDX = HW'(h);
      localparam int            SLOT  = t * HEAD_NUM + h;
      logic we;
      assign we = accept && (tok_cnt == T_IDX) && (head_cnt == H_IDX);
      head_collect_slot #(.W(VW)) u_slot (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .we    (we),
        .din   (in_data),
        .q     (matrix[SLOT*VW +: VW])
      );
    end
  end

endmodule

// File: tb/tb_head_collect.sv
// Randomized scoreboard bench for head_collect (8-bit, 2 tokens, 2 heads, 2 dims).
module tb_head_collect;

  localparam int DW = 8, SL = 2, HN = 2, HD = 2;
  localparam int VW = DW * HD;
  localparam int MW = DW * SL * HN * HD;
  localparam int FRAME = SL * HN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [MW-1:0] matrix;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [MW-1:0] mat;
    logic          err;
  } exp_t;
  exp_t sb[$];

  // Reference model: element store indexed [token][head][dim], beat count, flags.
  logic [DW-1:0] mem [SL][HN][HD];
  int   m_n    = 0;
  logic m_full = 1'b0;
  logic m_err  = 1'b0;
  logic ov_prev = 1'b0;

  head_collect #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .HEAD_NUM(HN), .HEAD_DIM(HD)) dut (
    .clk_p(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .matrix(matrix), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] model_mat();
    logic [MW-1:0] v = '0;
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < HN; h++)
        for (int d = 0; d < HD; d++)
          v[((t*HN+h)*HD+d)*DW +: DW] = mem[t][h][d];
    return v;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < HN; h++)
        for (int d = 0; d < HD; d++)
          mem[t][h][d] = '0;
    m_n = 0; m_full = 1'b0; m_err = 1'b0;
  endtask

  // Effect of one rising edge on the model, given the inputs held across it.
  task automatic model_edge(input logic v, input logic [VW-1:0] d, input logic l,
                            input logic clr, input logic ordy);
    int t, h;
    if (clr) begin
      m_n = 0; m_full = 1'b0; m_err = 1'b0;
    end else if (m_full) begin
      if (ordy) m_full = 1'b0;
    end else if (v) begin
      h = m_n / SL;
      t = m_n % SL;
      for (int k = 0; k < HD; k++) mem[t][h][k] = d[k*DW +: DW];
      if (l != (t == SL-1)) m_err = 1'b1;
      m_n++;
      if (m_n == FRAME) begin
        m_n = 0;
        m_full = 1'b1;
        sb.push_back('{mat: model_mat(), err: m_err});
      end
    end
  endtask

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after an edge: drive inputs, cross one edge, update the model.
  task automatic step(input logic v, input logic [VW-1:0] d, input logic l,
                      input logic clr, input logic ordy);
    in_valid = v; in_data = d; in_last = l; clear = clr; out_ready = ordy;
    @(posedge clk);
    model_edge(v, d, l, clr, ordy);
    #1;
  endtask

  function automatic logic good_last();
    return (m_n % SL) == SL-1;
  endfunction

  task automatic beat(input logic [VW-1:0] d, input logic l, input int maxgap);
    repeat ($urandom_range(0, maxgap)) step(1'b0, VW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, d, l, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (m_full) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: continuous model compare plus scoreboard pop on each new frame.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", MW'(out_valid), MW'(m_full));
    chk("in_ready", MW'(in_ready), MW'(!m_full));
    chk("err", MW'(err), MW'(m_err));
    chk("matrix", matrix, model_mat());
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        chk("frame_unexpected", MW'(1), MW'(0));
      end else begin
        e = sb.pop_front();
        chk("frame_matrix", matrix, e.mat);
        chk("frame_err", MW'(err), MW'(e.err));
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  localparam logic [MW-1:0] REF_MAT = 64'h0706_0302_0504_0100;

  initial begin
    logic [VW-1:0] d;
    logic l;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_matrix", matrix, '0);
    chk("reset_ready", MW'(in_ready), MW'(1));

    // In-order fill
    for (int i = 0; i < FRAME; i++) beat({8'(2*i+1), 8'(2*i)}, good_last(), 0);
    chk("fill_matrix", matrix, REF_MAT);
    chk("fill_valid", MW'(out_valid), MW'(1));
    chk("fill_ready", MW'(in_ready), MW'(0));
    chk("fill_err", MW'(err), MW'(0));

    // Backpressure with beats presented while full
    repeat (10) step(1'b1, VW'($urandom), 1'b0, 1'b0, 1'b0);
    chk("bp_matrix", matrix, REF_MAT);
    chk("bp_valid", MW'(out_valid), MW'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bp_release_valid", MW'(out_valid), MW'(0));
    chk("bp_release_ready", MW'(in_ready), MW'(1));

    // Gaps between beats
    for (int i = 0; i < FRAME; i++) beat({8'(2*i+1), 8'(2*i)}, good_last(), 3);
    chk("gap_matrix", matrix, REF_MAT);
    drain();

    // Framing error on beat 0
    beat(16'hAA00, 1'b1, 0);
    chk("err_set", MW'(err), MW'(1));
    for (int i = 1; i < FRAME; i++) beat(VW'($urandom), good_last(), 1);
    chk("err_frame_done", MW'(out_valid), MW'(1));
    drain();
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", MW'(err), MW'(1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("err_cleared", MW'(err), MW'(0));

    // Reset mid-frame
    for (int i = 0; i < 2; i++) beat(VW'($urandom), good_last(), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_matrix", matrix, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) beat(16'hC0C0 + VW'(i), good_last(), 0);
    chk("rst_fresh_matrix", matrix, 64'hC0C3_C0C1_C0C2_C0C0);
    drain();

    // Clear together with a beat after 3 beats
    for (int i = 0; i < 3; i++) beat(VW'($urandom), good_last(), 0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    chk("clr_valid", MW'(out_valid), MW'(0));
    chk("clr_ready", MW'(in_ready), MW'(1));
    for (int i = 0; i < FRAME; i++) beat(VW'($urandom), good_last(), 0);
    chk("clr_frame_done", MW'(out_valid), MW'(1));
    drain();

    // Random traffic
    for (int f = 0; f < 40; f++) begin
      while (!m_full) begin
        d = VW'($urandom);
        l = good_last();
        if ($urandom_range(0, 15) == 0) l = ~l;
        if ($urandom_range(0, 39) == 0) begin
          step(1'b1, d, l, 1'b1, 1'b0);
        end else begin
          beat(d, l, 2);
        end
      end
      repeat ($urandom_range(0, 4))
        step(1'(($urandom)), VW'($urandom), 1'(($urandom)), 1'b0, 1'b0);
      drain();
    end

    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", MW'(sb.size()), MW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/head_collect.md
HEAD_COLLECT -- requirements
Module: head_collect

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the signed element width in bits.
REQ-002 SHALL have parameter SEQ_LEN, default 128, giving the tokens per head.
REQ-003 SHALL have parameter HEAD_NUM, default 12, giving the number of heads.
REQ-004 SHALL have parameter HEAD_DIM, default 64, giving the elements per head vector.
REQ-005 SHALL have port clk_p, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port clear, input, 1 bit: synchronous frame flush.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, DATA_WIDTH*HEAD_DIM bits: one head vector of one token, with element d at bits [d*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port in_last, input, 1 bit: marks the final token of the current head.
REQ-012 SHALL have port matrix, output, DATA_WIDTH*SEQ_LEN*HEAD_NUM*HEAD_DIM bits: the packed tensor for the downstream head-merge stage.
REQ-013 SHALL have port out_valid, output, 1 bit: matrix holds a complete frame.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream has consumed the frame.
REQ-015 SHALL have port err, output, 1 bit: sticky framing error.

Function
REQ-016 SHALL accept a beat only when in_valid and in_ready are both 1 on a rising edge.
REQ-017 SHALL expect beat order to be head-major: for head h = 0..HEAD_NUM-1, tokens t = 0..SEQ_LEN-1; one frame is SEQ_LEN*HEAD_NUM beats.
REQ-018 SHALL write each accepted beat to matrix element (t,h,d) at bit offset ((t*HEAD_NUM+h)*HEAD_DIM+d)*DATA_WIDTH, using the internal counters tok_cnt and head_cnt.
REQ-019 SHALL have two states, FILL and FULL, with in_ready = 1 exactly when the state is FILL; in_ready is combinational from state only.
REQ-020 SHALL, in FILL, increment tok_cnt on each accepted beat; at SEQ_LEN-1 it wraps to 0 and head_cnt increments.
REQ-021 SHALL, on accepting the beat with tok_cnt = SEQ_LEN-1 and head_cnt = HEAD_NUM-1, go to FULL with out_valid = 1 from the next cycle (one-cycle latency) and both counters at 0.
REQ-022 SHALL, in FULL, hold matrix and out_valid stable until out_ready = 1; on that edge it goes to FILL with out_valid = 0, and new beats are accepted from the following cycle.
REQ-023 SHALL ignore in_valid while in FULL; no write and no counter change occur.
REQ-024 SHALL leave matrix contents unchanged on a FULL-to-FILL transition; elements are overwritten only by new beats.
REQ-025 SHALL set err on an accepted beat when in_last = 1 and tok_cnt ≠ SEQ_LEN-1, or when in_last = 0 and tok_cnt = SEQ_LEN-1; the beat is still written per the counters.
REQ-026 SHALL hold err set until rst_n or clear, and SHALL NOT let it alter sequencing.
REQ-027 SHALL give clear priority over all handshakes: state goes to FILL, counters and err to 0, out_valid to 0, matrix untouched, and a beat presented in the same cycle is dropped.
REQ-028 SHALL ignore out_ready while in FILL.
REQ-029 SHALL use pure bit placement for stored data, with no arithmetic or sign change.

Reset
REQ-030 SHALL, while rst_n = 0 (asynchronously), set state to FILL, tok_cnt and head_cnt to 0, out_valid to 0, err to 0, and matrix to all zeros.
REQ-031 SHALL, for reset mid-frame, discard the partial frame; the first beat after release is (t=0,h=0).
REQ-032 SHALL have in_ready = 1 in the first cycle after rst_n deasserts.

Verification (DATA_WIDTH=8, SEQ_LEN=2, HEAD_NUM=2, HEAD_DIM=2)
REQ-033 SHALL cover in-order fill: 4 beats with in_data 0x0100, 0x0302, 0x0504, 0x0706 and correct in_last -> one cycle after the 4th beat, out_valid = 1, in_ready = 0, matrix = 0x0706_0302_0504_0100, err = 0.
REQ-034 SHALL cover backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 and new data -> matrix unchanged, out_valid = 1, no writes; raise out_ready -> next cycle out_valid = 0, in_ready = 1.
REQ-035 SHALL cover input gaps: random in_valid gaps across the same 4 beats -> same matrix as REQ-033, and out_valid asserts exactly one cycle after the last accepted beat.
REQ-036 SHALL cover a framing error: in_last = 1 on beat 0 -> err = 1 from the next cycle; the frame still completes after 4 beats; err remains 1 until clear.
REQ-037 SHALL cover reset mid-frame: rst_n low after 2 beats -> matrix = 0 immediately; after release, 4 fresh beats complete a frame with no residue.
REQ-038 SHALL cover clear with a beat: clear = 1 with in_valid = 1 after 3 beats -> beat dropped, counters 0, out_valid stays 0; a full 4-beat frame then completes normally.
